// File: rtl/decode_idix.sv
// rtl/decode_idix.sv - uRISC decode/issue stage with 2-entry skid buffer feeding idix_p1
module decode_idix #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_if_p1,
  input  logic [15:0] pc_if_p1,
  input  logic        instr_valid_if_p1,
  output logic        decode_ready,
  input  logic        ix_ready,
  input  logic        flush,
  output logic        idix_valid,
  output logic        execute_valid_idix_p1,
  output logic        ldst_valid_idix_p1,
  output logic        jmp_idix_p1,
  output logic        branch_idix_p1,
  output logic [4:0]  opcode_idix_p1,
  output logic        rotate_shift_right_idix_p1,
  output logic [2:0]  rs_idix_p1,
  output logic [2:0]  rt_idix_p1,
  output logic [2:0]  rd_idix_p1,
  output logic [15:0] imm_idix_p1,
  output logic        wr_idix_p1,
  output logic        halt_idix_p1,
  output logic        excep_idix_p1,
  output logic [15:0] pc_p1
);

  if (DEPTH != 2) begin : g_depth_check
    $error("decode_idix supports only DEPTH=2");
  end

  typedef struct packed {
    logic        exe;
    logic        ldst;
    logic        jmp;
    logic        br;
    logic [4:0]  opcode;
    logic        rsr;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic        wr;
    logic        halt;
    logic        excep;
    logic [15:0] pc;
  } slot_t;

  typedef enum logic [1:0] {ST_RUN, ST_HALT_PEND, ST_HALTED} state_t;

  state_t state_q, state_d;
  slot_t  out_q, out_d, skid_q, skid_d, dec;
  logic   out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic   ready_q, ready_d;
  logic   is_nop, accept, issue, slot_in;

  // Decode the incoming instruction into an idix slot; unused fields stay zero
  always_comb begin
    dec        = '0;
    dec.opcode = instr_if_p1[15:11];
    dec.pc     = pc_if_p1;
    is_nop     = 1'b0;
    case (instr_if_p1[15:11])
      5'b00000: dec.halt = 1'b1;
      5'b00001: is_nop = 1'b1;
      5'b01000, 5'b01001: begin
        dec.exe = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rd = instr_if_p1[7:5]; dec.wr = 1'b1;
        dec.imm = {{11{instr_if_p1[4]}}, instr_if_p1[4:0]};
      end
      5'b01010, 5'b01011: begin
        dec.exe = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rd = instr_if_p1[7:5]; dec.wr = 1'b1;
        dec.imm = {11'd0, instr_if_p1[4:0]};
      end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        dec.exe = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rd = instr_if_p1[7:5]; dec.wr = 1'b1;
        dec.imm = {12'd0, instr_if_p1[3:0]};
        dec.rsr = instr_if_p1[12];
      end
      5'b10000: begin
        dec.ldst = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rt = instr_if_p1[7:5];
        dec.imm  = {{11{instr_if_p1[4]}}, instr_if_p1[4:0]};
      end
      5'b10001: begin
        dec.ldst = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rd = instr_if_p1[7:5]; dec.wr = 1'b1;
        dec.imm  = {{11{instr_if_p1[4]}}, instr_if_p1[4:0]};
      end
      5'b11011: begin
        dec.exe = 1'b1; dec.rs = instr_if_p1[10:8]; dec.rt = instr_if_p1[7:5];
        dec.rd  = instr_if_p1[4:2]; dec.wr = 1'b1; dec.rsr = instr_if_p1[1];
      end
      5'b01100, 5'b01101: begin
        dec.br  = 1'b1; dec.rs = instr_if_p1[10:8];
        dec.imm = {{8{instr_if_p1[7]}}, instr_if_p1[7:0]};
      end
      5'b00100: begin
        dec.jmp = 1'b1;
        dec.imm = {{5{instr_if_p1[10]}}, instr_if_p1[10:0]};
      end
      5'b00101: begin
        dec.jmp = 1'b1; dec.rs = instr_if_p1[10:8];
        dec.imm = {{8{instr_if_p1[7]}}, instr_if_p1[7:0]};
      end
      default: dec.excep = 1'b1;
    endcase
  end

  assign accept  = instr_valid_if_p1 && ready_q;
  assign issue   = out_v_q && ix_ready;
  assign slot_in = accept && !is_nop;

  // Skid buffer: new slots go to the output register when it frees up, else to the skid slot
  always_comb begin
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (out_v_q && !issue) begin
      if (slot_in) begin
        skid_v_d = 1'b1;
        skid_d   = dec;
      end
    end else if (skid_v_q) begin
      out_v_d  = 1'b1;
      out_d    = skid_q;
      skid_v_d = slot_in;
      if (slot_in) skid_d = dec;
    end else begin
      out_v_d = slot_in;
      if (slot_in) out_d = dec;
    end
  end

  // Halt FSM and registered ready; ready only when running and the skid slot will be free
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (!flush && accept && dec.halt) state_d = ST_HALT_PEND;
      ST_HALT_PEND: begin
        if (flush)                   state_d = ST_RUN;
        else if (issue && out_q.halt) state_d = ST_HALTED;
      end
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN) && !skid_v_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      out_q    <= '0;
      skid_q   <= '0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign decode_ready               = ready_q;
  assign idix_valid                 = out_v_q;
  assign execute_valid_idix_p1      = out_v_q & out_q.exe;
  assign ldst_valid_idix_p1         = out_v_q & out_q.ldst;
  assign jmp_idix_p1                = out_v_q & out_q.jmp;
  assign branch_idix_p1             = out_v_q & out_q.br;
  assign opcode_idix_p1             = out_v_q ? out_q.opcode : 5'd0;
  assign rotate_shift_right_idix_p1 = out_v_q & out_q.rsr;
  assign rs_idix_p1                 = out_v_q ? out_q.rs : 3'd0;
  assign rt_idix_p1                 = out_v_q ? out_q.rt : 3'd0;
  assign rd_idix_p1                 = out_v_q ? out_q.rd : 3'd0;
  assign imm_idix_p1                = out_v_q ? out_q.imm : 16'd0;
  assign wr_idix_p1                 = out_v_q & out_q.wr;
  assign halt_idix_p1               = out_v_q & out_q.halt;
  assign excep_idix_p1              = out_v_q & out_q.excep;
  assign pc_p1                      = out_v_q ? out_q.pc : RESET_PC;

endmodule

// File: tb/tb_decode_idix.sv
// tb/tb_decode_idix.sv - directed table and sequence checks for decode_idix
module tb_decode_idix;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_if_p1, pc_if_p1;
  logic        instr_valid_if_p1, decode_ready, ix_ready, flush, idix_valid;
  logic        execute_valid_idix_p1, ldst_valid_idix_p1, jmp_idix_p1, branch_idix_p1;
  logic [4:0]  opcode_idix_p1;
  logic        rotate_shift_right_idix_p1;
  logic [2:0]  rs_idix_p1, rt_idix_p1, rd_idix_p1;
  logic [15:0] imm_idix_p1, pc_p1;
  logic        wr_idix_p1, halt_idix_p1, excep_idix_p1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_idix #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .instr_if_p1(instr_if_p1), .pc_if_p1(pc_if_p1),
    .instr_valid_if_p1(instr_valid_if_p1), .decode_ready(decode_ready),
    .ix_ready(ix_ready), .flush(flush), .idix_valid(idix_valid),
    .execute_valid_idix_p1(execute_valid_idix_p1), .ldst_valid_idix_p1(ldst_valid_idix_p1),
    .jmp_idix_p1(jmp_idix_p1), .branch_idix_p1(branch_idix_p1),
    .opcode_idix_p1(opcode_idix_p1), .rotate_shift_right_idix_p1(rotate_shift_right_idix_p1),
    .rs_idix_p1(rs_idix_p1), .rt_idix_p1(rt_idix_p1), .rd_idix_p1(rd_idix_p1),
    .imm_idix_p1(imm_idix_p1), .wr_idix_p1(wr_idix_p1), .halt_idix_p1(halt_idix_p1),
    .excep_idix_p1(excep_idix_p1), .pc_p1(pc_p1)
  );

  typedef struct {
    logic [15:0] instr;
    logic        v, exe, ldst, jmp, br, rsr;
    logic [2:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        wr, halt, excep;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {9'd0, idix_valid, execute_valid_idix_p1, ldst_valid_idix_p1, jmp_idix_p1,
            branch_idix_p1, rotate_shift_right_idix_p1, rs_idix_p1, rt_idix_p1, rd_idix_p1,
            imm_idix_p1, wr_idix_p1, halt_idix_p1, excep_idix_p1, opcode_idix_p1, pc_p1};
  endfunction

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; instr_valid_if_p1 = 1'b0; ix_ready = 1'b0;
    instr_if_p1 = 16'h0; pc_if_p1 = 16'h0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    vec_t e;
    logic [63:0] exp;
    vecs[0]  = '{16'h4A3F, 1,1,0,0,0,0, 3'd2,3'd0,3'd1, 16'hFFFF, 1,0,0};
    vecs[1]  = '{16'h4125, 1,1,0,0,0,0, 3'd1,3'd0,3'd1, 16'h0005, 1,0,0};
    vecs[2]  = '{16'h539F, 1,1,0,0,0,0, 3'd3,3'd0,3'd4, 16'h001F, 1,0,0};
    vecs[3]  = '{16'hB55A, 1,1,0,0,0,1, 3'd5,3'd0,3'd2, 16'h000A, 1,0,0};
    vecs[4]  = '{16'hAFCF, 1,1,0,0,0,0, 3'd7,3'd0,3'd6, 16'h000F, 1,0,0};
    vecs[5]  = '{16'h8270, 1,0,1,0,0,0, 3'd2,3'd3,3'd0, 16'hFFF0, 0,0,0};
    vecs[6]  = '{16'h8CA7, 1,0,1,0,0,0, 3'd4,3'd0,3'd5, 16'h0007, 1,0,0};
    vecs[7]  = '{16'hD95E, 1,1,0,0,0,1, 3'd1,3'd2,3'd7, 16'h0000, 1,0,0};
    vecs[8]  = '{16'h6680, 1,0,0,0,1,0, 3'd6,3'd0,3'd0, 16'hFF80, 0,0,0};
    vecs[9]  = '{16'h687F, 1,0,0,0,1,0, 3'd0,3'd0,3'd0, 16'h007F, 0,0,0};
    vecs[10] = '{16'h2400, 1,0,0,1,0,0, 3'd0,3'd0,3'd0, 16'hFC00, 0,0,0};
    vecs[11] = '{16'h2BFE, 1,0,0,1,0,0, 3'd3,3'd0,3'd0, 16'hFFFE, 0,0,0};
    vecs[12] = '{16'hFFFF, 1,0,0,0,0,0, 3'd0,3'd0,3'd0, 16'h0000, 0,0,1};
    vecs[13] = '{16'h0800, 0,0,0,0,0,0, 3'd0,3'd0,3'd0, 16'h0000, 0,0,0};

    // Reset state and first ready
    rst = 1'b0; flush = 1'b0; instr_valid_if_p1 = 1'b0; ix_ready = 1'b0;
    instr_if_p1 = 16'h0; pc_if_p1 = 16'h0;
    step();
    chk("reset_outputs", all_out(), 64'd0);
    chk("reset_ready", {63'd0, decode_ready}, 64'd0);
    rst = 1'b1;
    #2;
    chk("ready_before_edge", {63'd0, decode_ready}, 64'd0);
    step();
    chk("ready_after_edge", {63'd0, decode_ready}, 64'd1);

    // Back-to-back decode table with execute always ready
    ix_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      e = vecs[i];
      instr_if_p1 = e.instr;
      pc_if_p1 = 16'h1000 + 16'(i * 2);
      instr_valid_if_p1 = 1'b1;
      step();
      exp = {9'd0, e.v, e.exe, e.ldst, e.jmp, e.br, e.rsr, e.rs, e.rt, e.rd, e.imm,
             e.wr, e.halt, e.excep,
             (e.v ? e.instr[15:11] : 5'd0), (e.v ? 16'h1000 + 16'(i * 2) : 16'h0000)};
      chk($sformatf("decode%0d_%h", i, e.instr), all_out(), exp);
      chk($sformatf("ready%0d", i), {63'd0, decode_ready}, 64'd1);
    end
    instr_valid_if_p1 = 1'b0;
    step();

    // Back-pressure: two accepted, third refused until space frees, order kept
    ix_ready = 1'b0;
    instr_if_p1 = 16'h4101; pc_if_p1 = 16'h2000; instr_valid_if_p1 = 1'b1;
    step();
    chk("bp_first_out", {47'd0, idix_valid, pc_p1}, {47'd0, 1'b1, 16'h2000});
    chk("bp_ready_one", {63'd0, decode_ready}, 64'd1);
    instr_if_p1 = 16'h4102; pc_if_p1 = 16'h2002;
    step();
    chk("bp_ready_full", {63'd0, decode_ready}, 64'd0);
    chk("bp_hold_a", {48'd0, pc_p1}, 64'h2000);
    instr_if_p1 = 16'h4103; pc_if_p1 = 16'h2004;
    step();
    step();
    chk("bp_stable", {47'd0, imm_idix_p1, pc_p1}, {15'd0, 16'h0001, 16'h2000});
    chk("bp_still_full", {63'd0, decode_ready}, 64'd0);
    ix_ready = 1'b1;
    step();
    chk("bp_issue_b", {47'd0, idix_valid, pc_p1}, {47'd0, 1'b1, 16'h2002});
    chk("bp_ready_back", {63'd0, decode_ready}, 64'd1);
    step();
    chk("bp_issue_c", {31'd0, idix_valid, imm_idix_p1, pc_p1}, {31'd0, 1'b1, 16'h0003, 16'h2004});
    instr_valid_if_p1 = 1'b0;
    step();
    chk("bp_drained", {63'd0, idix_valid}, 64'd0);

    // HALT accepted, LD refused, flush recovers to RUN
    ix_ready = 1'b0;
    instr_if_p1 = 16'h0000; pc_if_p1 = 16'h3000; instr_valid_if_p1 = 1'b1;
    step();
    chk("halt_slot", {46'd0, idix_valid, halt_idix_p1, pc_p1}, {46'd0, 2'b11, 16'h3000});
    chk("halt_ready_drop", {63'd0, decode_ready}, 64'd0);
    instr_if_p1 = 16'h8CA7; pc_if_p1 = 16'h3002;
    step();
    chk("halt_ld_refused", {47'd0, halt_idix_p1, pc_p1}, {47'd1, 16'h3000});
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halt_flush", {62'd0, idix_valid, decode_ready}, 64'd1);
    step();
    chk("ld_after_flush", {46'd0, idix_valid, ldst_valid_idix_p1, pc_p1}, {46'd0, 2'b11, 16'h3002});

    // HALT issues, then nothing more is accepted
    ix_ready = 1'b1;
    instr_if_p1 = 16'h0000; pc_if_p1 = 16'h3004;
    step();
    chk("halt2_slot", {47'd0, halt_idix_p1, pc_p1}, {47'd1, 16'h3004});
    instr_if_p1 = 16'h8CA7; pc_if_p1 = 16'h3006;
    step();
    chk("halted_empty", {62'd0, idix_valid, decode_ready}, 64'd0);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halted_stays", {62'd0, idix_valid, decode_ready}, 64'd0);

    // Flush while full, and flush dropping a same-cycle accept
    do_reset();
    ix_ready = 1'b0;
    instr_if_p1 = 16'h4101; pc_if_p1 = 16'h4000; instr_valid_if_p1 = 1'b1;
    step();
    instr_if_p1 = 16'h4102; pc_if_p1 = 16'h4002;
    step();
    instr_if_p1 = 16'h4103; pc_if_p1 = 16'h4004; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_full", {62'd0, idix_valid, decode_ready}, 64'd1);
    instr_if_p1 = 16'h4104; pc_if_p1 = 16'h4006;
    step();
    chk("one_entry", {47'd0, idix_valid, pc_p1}, {47'd0, 1'b1, 16'h4006});
    instr_if_p1 = 16'h4105; pc_if_p1 = 16'h4008; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid_if_p1 = 1'b0;
    chk("flush_drop_accept", {63'd0, idix_valid}, 64'd0);
    ix_ready = 1'b1;
    step();
    chk("flushed_never_seen", all_out(), 64'd0);

    // Asynchronous reset mid-stream clears outputs without a clock edge
    ix_ready = 1'b0;
    instr_if_p1 = 16'h4A3F; pc_if_p1 = 16'h5000; instr_valid_if_p1 = 1'b1;
    step();
    chk("pre_async", {47'd0, execute_valid_idix_p1, pc_p1}, {47'd1, 16'h5000});
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_out", all_out(), 64'd0);
    chk("async_reset_ready", {63'd0, decode_ready}, 64'd0);
    rst = 1'b1;
    instr_valid_if_p1 = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
